// File: rtl/spike_collector.sv
// spike_collector
// Collects the three row-result packets of one timestep from the row adder,
// builds a 3x3 spike map, keeps the latest residual potentials per row, and
// hands the finished map downstream with its timestep index.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_COLLECT | accepting row packets until rows 1, 2 and 3 have arrived
//  ST_SEND    | map presented on out_*, waiting for out_ready
module spike_collector #(
    parameter int WIDTH     = 39,
    parameter int WIDTH_D   = 8,
    parameter int TIMESTEPS = 10,
    parameter int TS_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_pkt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8:0]             out_map,
    output logic [TS_W-1:0]        out_ts,
    input  logic [1:0]             rd_row,
    output logic [3*WIDTH_D-1:0]   rd_data,
    output logic                   done,
    output logic [2:0]             err
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_SEND    = 1'b1
    } state_t;

    localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIMESTEPS - 1);

    state_t               state;
    state_t               state_nxt;

    // got[0] tracks row 1, got[2] tracks row 3
    logic [2:0]           got;
    logic [2:0]           map_r   [1:3];
    logic [2:0]           map_wr  [1:3];
    logic [3*WIDTH_D-1:0] res_r   [1:3];
    logic [TS_W-1:0]      ts;

    logic [1:0]           pkt_type;
    logic [1:0]           pkt_row;
    logic [2:0]           pkt_spike;
    logic [3*WIDTH_D-1:0] pkt_res;
    logic                 unused_dest;

    logic                 in_hs;
    logic                 out_hs;
    logic                 type_bad;
    logic                 row_bad;
    logic                 pkt_ok;
    logic [2:0]           row_oh;
    logic                 complete;

    // packet field unpacking; the destination field has no meaning here
    always_comb begin
        pkt_type    = in_pkt[38:37];
        pkt_row     = in_pkt[28:27];
        pkt_spike   = in_pkt[26:24];
        pkt_res     = in_pkt[3*WIDTH_D-1:0];
        unused_dest = ^in_pkt[36:29];
    end

    // handshake qualification and completion detect
    always_comb begin
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid && out_ready;
        type_bad = in_hs && (pkt_type != 2'b11);
        row_bad  = in_hs && (pkt_type == 2'b11) && (pkt_row == 2'd0);
        pkt_ok   = in_hs && (pkt_type == 2'b11) && (pkt_row != 2'd0);
        row_oh   = 3'b000;
        case (pkt_row)
            2'd1:    row_oh = 3'b001;
            2'd2:    row_oh = 3'b010;
            2'd3:    row_oh = 3'b100;
            default: row_oh = 3'b000;
        endcase
        complete = pkt_ok && ((got | row_oh) == 3'b111);
    end

    // spike map as it will look after this cycle's write, used to load out_map
    always_comb begin
        for (int r = 1; r <= 3; r++) begin
            map_wr[r] = (pkt_ok && (pkt_row == 2'(r))) ? pkt_spike : map_r[r];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (complete)  state_nxt = ST_SEND;
            ST_SEND:    if (out_ready) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    // decoded output
    always_comb begin
        in_ready = (state == ST_COLLECT);
    end

    // row-arrival flags and spike map; cleared when the map is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got <= 3'b000;
            for (int r = 1; r <= 3; r++) map_r[r] <= 3'b000;
        end else if (out_hs) begin
            got <= 3'b000;
            for (int r = 1; r <= 3; r++) map_r[r] <= 3'b000;
        end else if (pkt_ok) begin
            got <= got | row_oh;
            for (int r = 1; r <= 3; r++) map_r[r] <= map_wr[r];
        end
    end

    // residuals are replaced per packet and survive across timesteps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r <= 3; r++) res_r[r] <= '0;
        end else if (pkt_ok) begin
            for (int r = 1; r <= 3; r++) begin
                if (pkt_row == 2'(r)) res_r[r] <= pkt_res;
            end
        end
    end

    // output map is captured on completion and held for the whole send phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_map   <= 9'd0;
        end else begin
            out_valid <= (state_nxt == ST_SEND);
            if (out_hs) begin
                out_map <= 9'd0;
            end else if (complete) begin
                out_map <= {map_wr[1], map_wr[2], map_wr[3]};
            end
        end
    end

    // timestep counter and end-of-inference pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts   <= '0;
            done <= 1'b0;
        end else begin
            done <= out_hs && (ts == TS_LAST);
            if (out_hs) begin
                ts <= (ts == TS_LAST) ? '0 : ts + 1'b1;
            end
        end
    end

    always_comb begin
        out_ts = ts;
    end

    // sticky error flags {bad_type, bad_row, dup_row}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 3'b000;
        end else begin
            if (type_bad)                     err[2] <= 1'b1;
            if (row_bad)                      err[1] <= 1'b1;
            if (pkt_ok && ((got & row_oh) != 3'b000)) err[0] <= 1'b1;
        end
    end

    // residual read port, zero for the unused select value
    always_comb begin
        rd_data = '0;
        case (rd_row)
            2'd1:    rd_data = res_r[1];
            2'd2:    rd_data = res_r[2];
            2'd3:    rd_data = res_r[3];
            default: rd_data = '0;
        endcase
    end

endmodule

// File: doc/spike_collector.md
# spike_collector

Clocked collector directly downstream of the row adder. Accepts one 39-bit row-result packet per handshake, unpacks the row's 3-bit spike vector and three 8-bit residual membrane potentials, and holds them in a 3x3 spike map and a residual register file. Once all three rows of a timestep have arrived, it emits the 9-bit spike map with its timestep index, then begins the next timestep. Residuals stay readable for the next pass.

## Interface
- WIDTH, 39, input packet width
- WIDTH_D, 8, residual potential width
- TIMESTEPS, 10, timesteps per inference (2..256)
- TS_W, 8, timestep index width
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input packet valid
- in_ready  output  1  block can accept a packet
- in_pkt  input  WIDTH  fields: [38:37] type, [36:29] dest (ignored), [28:27] row, [26:24] spike{c1,c2,c3}, [23:16] res c1, [15:8] res c2, [7:0] res c3
- out_valid  output  1  spike map valid
- out_ready  input  1  consumer accepts spike map
- out_map  output  9  {row1 spike[2:0], row2, row3}
- out_ts  output  TS_W  timestep index of out_map
- rd_row  input  2  residual read select, 1..3
- rd_data  output  3*WIDTH_D  {c1,c2,c3} residuals of rd_row, combinational; 0 for rd_row=0
- done  output  1  one-cycle pulse when the last timestep's map is accepted
- err  output  3  sticky {bad_type, bad_row, dup_row}

## Operation
- States: COLLECT, SEND.
- COLLECT: in_ready=1. On an in_valid&&in_ready handshake:
  - type!=2'b11: drop the packet, set err[2].
  - row==0: drop the packet, set err[1].
  - Otherwise write spike to map[row] and residuals to res[row], and set got[row]. If got[row] was already set, set err[0]; the new data overwrites the old.
- Transition to SEND when got becomes 3'b111, including on the handshake that completes it.
- SEND: in_ready=0, out_valid=1, out_map/out_ts held stable until out_ready.
  - On the out handshake: clear got and the spike map, then advance ts.
  - ts wraps from TIMESTEPS-1 to 0. done pulses in the cycle after the handshake that wraps ts.
  - Return to COLLECT.
- Residuals are never cleared except by reset. They are not summed: each packet replaces them.
- err bits clear only on reset.
- Reset: state=COLLECT, got=0, map=0, residuals=0, ts=0. Outputs after reset: in_ready=1, out_valid=0, out_map=0, out_ts=0, done=0, err=0.
- Reset asserted mid-SEND aborts the map. The map is lost, with no partial output.

## Timing
- Registered outputs: out_valid, out_map, out_ts, done, err. in_ready is decoded from state.
- Packet latency: the third distinct row accepted at edge N gives out_valid=1 after edge N.
- out_valid falls after the edge at which out_ready is sampled high. in_ready rises in the same cycle.
- Minimum period per timestep: 3 input cycles + 1 output cycle.
- in_valid during SEND is ignored (in_ready=0). The producer must hold it.
- A handshake on the current cycle is visible on rd_data after that edge.
- Dropped or erroneous packets still complete their handshake and consume one cycle.

## Test plan
- Reset with no traffic -> in_ready=1, out_valid=0, err=0, rd_data=0 for all rows.
- Send rows 1,2,3 with spikes 101/000/011 and residuals (5,14,8)/(0,63,1)/(2,2,2) -> one cycle later out_map=9'b101000011, out_ts=0; rd_row=2 reads {0,63,1}; after out_ready, ts=1.
- Rows arriving in order 3,1,2 with out_ready held low 4 cycles -> out_map stable and in_ready=0 throughout; an in_valid presented meanwhile is not consumed.
- Row 1 sent twice, then rows 2 and 3 -> err[0]=1; map takes the second row-1 packet; output occurs after row 3.
- Packets with type 2'b01 and with row=0 -> both accepted and dropped; err=3'b110; got unchanged.
- TIMESTEPS=3, run 3 full timesteps -> out_ts 0,1,2; done pulses once after the third out handshake; ts returns to 0. Assert rst_n low mid-SEND -> out_valid=0 immediately and all state is cleared.
